regfile_param: RTL
==================

# regfile_param

Parametrised multi-port register file for the datapath designs. It generalises the fixed 4×8 single-port file to configurable width and depth. It has one write port and two independent read ports, an optional hardwired-zero register 0, optional same-cycle write-to-read bypass, and per-register valid flags. It sits between the ALU/datapath write-back and operand fetch.

## Interface
- W, default 8: data width in bits (≥1).
- AW, default 2: address width; depth N = 2**AW (≥1, so N ≥ 2).
- ZERO_R0, default 0: 1 makes register 0 read as zero and ignore writes.
- BYP, default 1: 1 forwards write data to a read port addressing the register being written in the same cycle.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- we  in  1  write enable.
- wa  in  AW  write address.
- wd  in  W  write data.
- clr  in  1  synchronous clear of all valid flags; data is untouched.
- ra1  in  AW  read address, port 1.
- ra2  in  AW  read address, port 2.
- rd1  out  W  read data, port 1 (combinational).
- rd2  out  W  read data, port 2 (combinational).
- vld  out  N  valid flag per register; bit i belongs to register i.
- wcnt  out  8  count of accepted writes, wrapping modulo 256.

## Operation
- Storage: N registers of W bits, each with a valid flag.
- Write: on a rising clk edge with we=1, reg[wa] <= wd and vld[wa] <= 1. wcnt increments by 1.
- With ZERO_R0=1 and wa=0, the write is dropped and wcnt does not increment. Such a write is not an accepted write.
- Read: rdK = reg[raK] and is combinational; there is no read enable.
- ZERO_R0=1: rdK = 0 whenever raK=0, regardless of bypass. vld[0] is held at 1 at all times, including during reset.
- Bypass with BYP=1: if we=1 and wa=raK and the write is accepted, rdK = wd in the same cycle. BYP=0 returns the old contents until the edge.
- Both read ports may address the same register, or the write address, simultaneously. Each port resolves independently.
- clr: on a rising edge with clr=1, all vld bits are cleared, except vld[0] when ZERO_R0=1.
- clr and we together: the entry being written ends with vld[wa]=1 and all other bits end at 0. Write wins for its own entry.
- Valid flags are status only. Reads are never blocked by vld=0.

## Timing
- Write latency: 1 cycle. Data is visible on rd without bypass in the cycle after the write edge; with bypass it is visible in the same cycle.
- Read latency: 0 cycles, combinational from ra, storage and bypass.
- Reset (rst=1) is asynchronous. It takes effect immediately and independently of clk:
  - all registers = 0, so rd1 = rd2 = 0;
  - vld = 0, except vld[0]=1 when ZERO_R0=1;
  - wcnt = 0.
- While rst=1, we and clr are ignored.
- rst asserted mid-write, or coincident with a clk edge, discards that write.
- Deassertion of rst is clean. The first edge after deassertion accepts a write normally.
- wcnt wraps from 255 to 0 on the next accepted write.
- Every address value in range 0..N-1 is valid. No out-of-range condition exists.

## Test plan
- Reset: drive rst=1 mid-cycle with no clk edge. Required: rd1=rd2=0, vld=0, wcnt=0 immediately. Then write 0xA5 to reg 2, and in the next cycle set ra1=2. Required: rd1=0xA5, vld=4'b0100, wcnt=1.
- Bypass (BYP=1): reg 3 holds 0x11. Apply we=1, wa=3, wd=0x7E with ra1=ra2=3, before the edge. Required: rd1=rd2=0x7E. With BYP=0 the same stimulus gives rd1=rd2=0x11 before the edge and 0x7E after it.
- Zero register (ZERO_R0=1): write 0xFF to reg 0. Required: rd1=0 with ra1=0, wcnt unchanged, and vld[0]=1 through reset and clr.
- Clear vs write: vld=4'b1110. Apply clr=1 together with we=1, wa=1. Required after the edge: vld=4'b0010, and data in regs 2 and 3 is unchanged.
- Counter wrap: perform 256 accepted writes from reset. Required: wcnt=0. The 257th write gives wcnt=1.
- Async reset mid-operation: apply rst=1 for 3 ns, overlapping a clk edge with we=1, wa=1, wd=0x3C. Required: reg 1 reads 0, vld[1]=0, wcnt=0.

Source files
------------

// File: rtl/regfile_param.sv
// Parametrised register file: one write port, two combinational read ports, per-register valid flags.
// Latency: writes land on the next rising clk edge; reads are combinational (same-cycle bypass when BYP=1).
// Backpressure: none; every write is accepted except a write to register 0 when ZERO_R0=1.
module regfile_param #(
    parameter int W       = 8,
    parameter int AW      = 2,
    parameter int ZERO_R0 = 0,
    parameter int BYP     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [AW-1:0]        wa,
    input  logic [W-1:0]         wd,
    input  logic                 clr,
    input  logic [AW-1:0]        ra1,
    input  logic [AW-1:0]        ra2,
    output logic [W-1:0]         rd1,
    output logic [W-1:0]         rd2,
    output logic [(2**AW)-1:0]   vld,
    output logic [7:0]           wcnt
);

    localparam int N = 2 ** AW;

    // Register 0 keeps its valid flag set from reset onward when it is hardwired to zero.
    localparam logic [N-1:0] RST_VLD = {{(N-1){1'b0}}, (ZERO_R0 != 0)};

    logic [W-1:0] regs_q [N];
    logic [W-1:0] regs_d [N];
    logic [N-1:0] vld_q;
    logic [N-1:0] vld_d;
    logic [7:0]   wcnt_q;
    logic [7:0]   wcnt_d;
    logic         wr_acc;

    // A write counts only outside reset and when it does not target a hardwired-zero register 0.
    always_comb begin
        wr_acc = we && !rst && !((ZERO_R0 != 0) && (wa == '0));
    end

    // Next-state for storage, valid flags and write counter; a write beats clr for its own entry.
    always_comb begin
        regs_d = regs_q;
        vld_d  = vld_q;
        wcnt_d = wcnt_q;
        if (clr) begin
            vld_d = '0;
        end
        if (wr_acc) begin
            regs_d[wa] = wd;
            vld_d[wa]  = 1'b1;
            wcnt_d     = wcnt_q + 8'd1;
        end
        if (ZERO_R0 != 0) begin
            vld_d[0] = 1'b1;
        end
    end

    // State registers with asynchronous reset; reset wins over any coincident write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                regs_q[i] <= '0;
            end
            vld_q  <= RST_VLD;
            wcnt_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                regs_q[i] <= regs_d[i];
            end
            vld_q  <= vld_d;
            wcnt_q <= wcnt_d;
        end
    end

    // Read mux shared by both ports: zero register first, then bypass, then stored value.
    function automatic logic [W-1:0] rd_sel(input logic [AW-1:0] ra);
        logic [W-1:0] r;
        r = regs_q[ra];
        if ((BYP != 0) && wr_acc && (wa == ra)) begin
            r = wd;
        end
        if ((ZERO_R0 != 0) && (ra == '0)) begin
            r = '0;
        end
        return r;
    endfunction

    // Both read ports resolve independently and combinationally.
    always_comb begin
        rd1 = rd_sel(ra1);
        rd2 = rd_sel(ra2);
    end

    assign vld  = vld_q;
    assign wcnt = wcnt_q;

endmodule
